// File: rtl/apb_timer_core.sv
// APB slave register file and 64-bit prescaled counter for the system timer.
// Provides TCR/TDR/TCMP/THCSR, returns the interrupt block's TIER/TISR on reads,
// and forwards a committed-write strobe so that block can decode its own registers.
module apb_timer_core #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic        pready,
  output logic        pslverr,
  output logic [31:0] prdata,
  input  logic        halt_req,
  input  logic [31:0] tier_in,
  input  logic [31:0] tisr_in,
  output logic        wr_en,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [63:0] cnt,
  output logic [63:0] tcmp
);

  localparam logic [4:0] OFF_TCR   = 5'h00;
  localparam logic [4:0] OFF_TDR0  = 5'h04;
  localparam logic [4:0] OFF_TDR1  = 5'h08;
  localparam logic [4:0] OFF_TCMP0 = 5'h0C;
  localparam logic [4:0] OFF_TCMP1 = 5'h10;
  localparam logic [4:0] OFF_TIER  = 5'h14;
  localparam logic [4:0] OFF_TISR  = 5'h18;
  localparam logic [4:0] OFF_THCSR = 5'h1C;

  // Byte-lane merge of a write into an existing word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = strb[i] ? nw[i*8 +: 8] : old[i*8 +: 8];
    return r;
  endfunction

  logic       timer_en, div_en, halt_en;
  logic [3:0] div_val;
  logic [7:0] div_cnt, div_lim;

  logic       in_win, done, wr_commit;
  logic [4:0] off;
  logic       sel_tcr, sel_tdr0, sel_tdr1, sel_tcmp0, sel_tcmp1, sel_thcsr;
  logic       new_en, new_den, tcr_err, tcr_ok, stop_clr;
  logic [3:0] new_dv;
  logic       halted, run, tick;
  logic [31:0] rdata;

  assign in_win    = (paddr[31:5] == BASE_ADDR[31:5]);
  assign off       = paddr[4:0];
  assign done      = psel & penable & pready;
  assign wr_commit = done & pwrite & in_win;

  assign sel_tcr   = wr_commit & (off == OFF_TCR);
  assign sel_tdr0  = wr_commit & (off == OFF_TDR0);
  assign sel_tdr1  = wr_commit & (off == OFF_TDR1);
  assign sel_tcmp0 = wr_commit & (off == OFF_TCMP0);
  assign sel_tcmp1 = wr_commit & (off == OFF_TCMP1);
  assign sel_thcsr = wr_commit & (off == OFF_THCSR);

  // Candidate TCR fields after strobe merge; a rejected write leaves TCR untouched.
  assign new_en   = pstrb[0] ? pwdata[0]    : timer_en;
  assign new_den  = pstrb[0] ? pwdata[1]    : div_en;
  assign new_dv   = pstrb[1] ? pwdata[11:8] : div_val;
  assign tcr_err  = (new_dv > 4'd8) |
                    (timer_en & ((new_den != div_en) | (new_dv != div_val)));
  assign tcr_ok   = sel_tcr & ~tcr_err;
  assign stop_clr = tcr_ok & timer_en & ~new_en;

  assign pslverr = sel_tcr & tcr_err;
  assign wr_en   = done & pwrite;
  assign addr    = paddr;
  assign wdata   = pwdata;

  // Prescaler limit is 2^div_val - 1; div_val never exceeds 8 once accepted.
  assign div_lim = 8'hFF >> (4'd8 - div_val);
  assign halted  = halt_en & halt_req;
  assign run     = timer_en & ~halted;
  assign tick    = run & (~div_en | (div_cnt == div_lim));

  // Registered pready: low on the first access cycle, high on the second.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pready <= 1'b0;
    else        pready <= psel & penable & ~pready;

  // Control/compare registers.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      timer_en <= 1'b0;
      div_en   <= 1'b0;
      div_val  <= 4'd1;
      halt_en  <= 1'b0;
      tcmp     <= '1;
    end else begin
      if (tcr_ok) begin
        timer_en <= new_en;
        div_en   <= new_den;
        div_val  <= new_dv;
      end
      if (sel_thcsr && pstrb[0]) halt_en <= pwdata[0];
      if (sel_tcmp0) tcmp[31:0]  <= merge(tcmp[31:0],  pwdata, pstrb);
      if (sel_tcmp1) tcmp[63:32] <= merge(tcmp[63:32], pwdata, pstrb);
    end

  // Counter and prescaler; a software TDR write overrides that cycle's increment.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt     <= '0;
      div_cnt <= '0;
    end else if (stop_clr) begin
      cnt     <= '0;
      div_cnt <= '0;
    end else begin
      if (run && div_en) div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
      if (sel_tdr0 || sel_tdr1) begin
        if (sel_tdr0) cnt[31:0]  <= merge(cnt[31:0],  pwdata, pstrb);
        if (sel_tdr1) cnt[63:32] <= merge(cnt[63:32], pwdata, pstrb);
      end else if (tick) begin
        cnt <= cnt + 64'd1;
      end
    end

  // Read mux; reserved offsets and out-of-window addresses return 0.
  always_comb begin
    rdata = '0;
    if (in_win) begin
      case (off)
        OFF_TCR:   rdata = {20'd0, div_val, 6'd0, div_en, timer_en};
        OFF_TDR0:  rdata = cnt[31:0];
        OFF_TDR1:  rdata = cnt[63:32];
        OFF_TCMP0: rdata = tcmp[31:0];
        OFF_TCMP1: rdata = tcmp[63:32];
        OFF_TIER:  rdata = tier_in;
        OFF_TISR:  rdata = tisr_in;
        OFF_THCSR: rdata = {30'd0, halted, halt_en};
        default:   rdata = '0;
      endcase
    end
  end

  // prdata only carries data on a read completion cycle.
  assign prdata = (done & ~pwrite) ? rdata : 32'd0;

endmodule

// File: tb/tb_apb_timer_core.sv
// Self-checking bench for apb_timer_core: behavioural register/counter model
// checked against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_apb_timer_core;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk = 0, rst_n = 0;
  logic        psel = 0, penable = 0, pwrite = 0;
  logic [31:0] paddr = 0, pwdata = 0;
  logic [3:0]  pstrb = 0;
  logic        pready, pslverr, wr_en;
  logic [31:0] prdata, addr, wdata;
  logic        halt_req = 0;
  logic [31:0] tier_in = 32'hA5A5_0001, tisr_in = 32'h0000_0003;
  logic [63:0] cnt, tcmp;

  int checks = 0, errors = 0;
  bit started = 0;

  apb_timer_core #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .pslverr(pslverr),
    .prdata(prdata), .halt_req(halt_req), .tier_in(tier_in), .tisr_in(tisr_in),
    .wr_en(wr_en), .addr(addr), .wdata(wdata), .cnt(cnt), .tcmp(tcmp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_tcr;      // TCR as a word: bit0 en, bit1 div, [11:8] div_val
  logic [63:0] m_cnt, m_tcmp;
  logic        m_halt_en, m_pready;
  int          m_pre;      // enabled cycles since the last prescaled tick

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i] ? n[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h20);
  endfunction

  function automatic bit tcr_bad(input logic [31:0] nt);
    return (nt[11:8] > 4'd8) || (m_tcr[0] && (nt[11:8] != m_tcr[11:8] || nt[1] != m_tcr[1]));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!in_win(a)) return 32'd0;
    case (a - BASE)
      32'h00: return m_tcr;
      32'h04: return m_cnt[31:0];
      32'h08: return m_cnt[63:32];
      32'h0C: return m_tcmp[31:0];
      32'h10: return m_tcmp[63:32];
      32'h14: return tier_in;
      32'h18: return tisr_in;
      32'h1C: return {30'd0, m_halt_en & halt_req, m_halt_en};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic done, wc, tick;
    logic [31:0] off, nt;
    logic [63:0] cnt_n;
    int pre_n;
    if (!rst_n) begin
      m_tcr = 32'h100; m_cnt = 0; m_tcmp = '1; m_halt_en = 0; m_pre = 0; m_pready = 0;
    end else begin
      done  = psel && penable && m_pready;
      wc    = done && pwrite && in_win(paddr);
      off   = paddr - BASE;
      tick  = 0;
      pre_n = m_pre;
      if (m_tcr[0] && !(m_halt_en && halt_req)) begin
        if (m_tcr[1]) begin
          pre_n = m_pre + 1;
          if (pre_n == (1 << m_tcr[11:8])) begin tick = 1; pre_n = 0; end
        end else tick = 1;
      end
      cnt_n = tick ? m_cnt + 64'd1 : m_cnt;
      if (wc) begin
        case (off)
          32'h00: begin
            nt = bmerge(m_tcr, pwdata, pstrb) & 32'h0000_0F03;
            if (!tcr_bad(nt)) begin
              if (m_tcr[0] && !nt[0]) begin cnt_n = 0; pre_n = 0; end
              m_tcr = nt;
            end
          end
          32'h04: cnt_n = {m_cnt[63:32], bmerge(m_cnt[31:0], pwdata, pstrb)};
          32'h08: cnt_n = {bmerge(m_cnt[63:32], pwdata, pstrb), m_cnt[31:0]};
          32'h0C: m_tcmp[31:0]  = bmerge(m_tcmp[31:0], pwdata, pstrb);
          32'h10: m_tcmp[63:32] = bmerge(m_tcmp[63:32], pwdata, pstrb);
          32'h1C: if (pstrb[0]) m_halt_en = pwdata[0];
          default: ;
        endcase
      end
      m_cnt    = cnt_n;
      m_pre    = pre_n;
      m_pready = psel && penable && !m_pready;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) if (started) begin
    logic done;
    done = psel && penable && m_pready;
    chk("pready",  pready,  m_pready);
    chk("wr_en",   wr_en,   done && pwrite);
    chk("pslverr", pslverr, done && pwrite && in_win(paddr) && (paddr - BASE == 0) &&
                            tcr_bad(bmerge(m_tcr, pwdata, pstrb) & 32'h0000_0F03));
    chk("prdata",  prdata,  (done && !pwrite) ? m_read(paddr) : 32'd0);
    chk("cnt",     cnt,     m_cnt);
    chk("tcmp",    tcmp,    m_tcmp);
    chk("addr",    addr,    paddr);
    chk("wdata",   wdata,   pwdata);
  end

  // ---------------- APB driver ----------------
  task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic e,
                     output logic we);
    int n;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    chk("wait_state", pready, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!pready && n < 8);
    chk("ready_lat", n, 1);
    rd = prdata; e = pslverr; we = wr_en;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  logic [31:0] rd;
  logic        er, we;
  logic [63:0] c0;

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    apb(1, BASE + off, d, 4'hF, rd, er, we);
  endtask
  task automatic rdreg(input logic [31:0] off);
    apb(0, BASE + off, 32'd0, 4'h0, rd, er, we);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    started = 1;

    // 1. reset values
    chk("rst_cnt", cnt, 64'd0);
    rdreg(32'h00); chk("rst_tcr", rd, 32'h100);
    rdreg(32'h0C); chk("rst_tcmp0", rd, 32'hFFFF_FFFF);
    rdreg(32'h10); chk("rst_tcmp1", rd, 32'hFFFF_FFFF);

    // 2. undivided counting, then stop clears
    wr(32'h00, 32'h1);
    @(negedge clk); c0 = cnt;
    repeat (10) @(negedge clk);
    chk("run10", cnt - c0, 64'd10);
    wr(32'h00, 32'h0);
    chk("stop_clr", cnt, 64'd0);

    // 3. divided counting and rejected TCR writes
    wr(32'h00, 32'h203);
    @(negedge clk); c0 = cnt;
    repeat (8) @(negedge clk);
    chk("div4", cnt - c0, 64'd2);
    wr(32'h00, 32'h303); chk("err_run_chg", er, 1'b1);
    rdreg(32'h00); chk("tcr_kept", rd, 32'h203);
    wr(32'h00, 32'h202); chk("stop_ok", er, 1'b0);
    wr(32'h00, 32'h903); chk("err_dv9", er, 1'b1);
    rdreg(32'h00); chk("tcr_kept2", rd, 32'h202);
    wr(32'h00, 32'h0);

    // 4. 64-bit wrap and carry
    wr(32'h04, 32'hFFFF_FFFF); wr(32'h08, 32'hFFFF_FFFF); wr(32'h00, 32'h1);
    @(posedge clk); #1; chk("wrap", cnt, 64'd0);
    wr(32'h00, 32'h0);
    wr(32'h04, 32'hFFFF_FFFF); wr(32'h08, 32'h0); wr(32'h00, 32'h1);
    @(posedge clk); #1; chk("carry", cnt, 64'h1_0000_0000);
    wr(32'h00, 32'h0);

    // 5. debug halt
    wr(32'h1C, 32'h1); wr(32'h00, 32'h1);
    @(posedge clk); #1; halt_req = 1; c0 = cnt;
    rdreg(32'h1C); chk("thcsr_ack", rd, 32'h3);
    chk("halt_frozen", cnt, c0);
    @(posedge clk); #1; halt_req = 0;
    @(posedge clk); #1; chk("halt_resume", cnt, c0 + 64'd1);
    wr(32'h1C, 32'h0);
    @(posedge clk); #1; halt_req = 1; c0 = cnt;
    repeat (3) @(posedge clk); #1;
    chk("halt_dis", cnt, c0 + 64'd3);
    halt_req = 0;
    wr(32'h00, 32'h0);

    // 6. passthrough strobe, TIER read, byte strobes
    apb(1, BASE + 32'h18, 32'h1, 4'hF, rd, er, we);
    chk("tisr_wr_en", we, 1'b1);
    @(negedge clk); chk("wr_en_pulse", wr_en, 1'b0);
    rdreg(32'h14); chk("tier_rd", rd, tier_in);
    apb(1, BASE + 32'h0C, 32'h1234_5678, 4'b0001, rd, er, we);
    rdreg(32'h0C); chk("strb_b0", rd, 32'hFFFF_FF78);

    // reset in the middle of a transfer
    @(posedge clk); #1; psel = 1; pwrite = 1; paddr = BASE + 32'h10; pwdata = 0; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1;
    @(posedge clk); #1; rst_n = 0;
    #1 chk("rst_mid_pready", pready, 1'b0);
    chk("rst_mid_tcmp", tcmp, 64'hFFFF_FFFF_FFFF_FFFF);
    psel = 0; penable = 0; pwrite = 0;
    @(posedge clk); #1 rst_n = 1;
    rdreg(32'h10); chk("rst_mid_rd", rd, 32'hFFFF_FFFF);

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      int r;
      logic [31:0] a, d;
      logic [3:0]  s;
      r = $urandom_range(0, 99);
      if (r < 8)       a = BASE + 32'h20 + ($urandom_range(0, 7) << 2);
      else if (r < 11) a = BASE - 32'h4;
      else if (r < 15) a = BASE + $urandom_range(0, 31);
      else             a = BASE + ($urandom_range(0, 7) << 2);
      d = $urandom;
      if (a == BASE) d = {20'd0, 4'($urandom_range(0, 9)), 6'd0, 2'($urandom)};
      s = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 9) < 3) halt_req = ~halt_req;
      tier_in = $urandom; tisr_in = $urandom;
      apb($urandom_range(0, 1) == 1, a, d, s, rd, er, we);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    started = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_timer_core.md
Name: apb_timer_core

Overview:
APB slave register file and 64-bit prescaled counter for the system timer at base 0x2000_0000. It sits directly upstream of the timer interrupt block, which it feeds with the live count (cnt), the compare value (tcmp) and a decoded APB write strobe (wr_en/addr/wdata). It also returns that block's TIER/TISR values on APB reads. One wait state per APB transfer, byte strobes, and a debug-halt handshake.

Parameters:
BASE_ADDR, 32'h2000_0000, timer register window base; offsets below are relative to it.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  32  APB address
pwdata  in  32  APB write data
pstrb  in  4  APB byte strobes
pready  out  1  APB ready
pslverr  out  1  APB error
prdata  out  32  APB read data
halt_req  in  1  debug halt request
tier_in  in  32  TIER value from interrupt block
tisr_in  in  32  TISR value from interrupt block
wr_en  out  1  committed-write pulse to interrupt block
addr  out  32  paddr passthrough
wdata  out  32  pwdata passthrough
cnt  out  64  {TDR1,TDR0}
tcmp  out  64  {TCMP1,TCMP0}

Behaviour:
- Register map (offset, reset value):
  - 0x00 TCR: [0] timer_en, [1] div_en, [11:8] div_val; reset 0x0000_0100.
  - 0x04 TDR0: 0.
  - 0x08 TDR1: 0.
  - 0x0C TCMP0: 0xFFFF_FFFF.
  - 0x10 TCMP1: 0xFFFF_FFFF.
  - 0x14 TIER: read-only here; returns tier_in.
  - 0x18 TISR: read-only here; returns tisr_in.
  - 0x1C THCSR: [0] halt_en (reset 0), [1] halt_ack (read-only).
  - Other offsets inside the window: read 0, writes ignored, no error.
  - Addresses outside the window: no decode, pready still follows the handshake.
- APB handshake:
  - Registered pready: 0 in the first access cycle (psel&penable), 1 in the second. This gives exactly one wait state.
  - pready is cleared the cycle after completion. Reset value 0.
  - Transfer completes when psel&penable&pready.
  - A write commits only on its completion cycle. A read drives prdata on its completion cycle and prdata=0 otherwise.
  - pslverr is valid only on the completion cycle and is 0 otherwise.
- Byte strobes: pstrb[i] gates byte i for writes to TCR, TDR0/1, TCMP0/1 and THCSR. Reserved bits read 0.
- pslverr=1, with the write fully rejected (no register changes), in either case:
  - A TCR write with div_val>8.
  - A TCR write that changes div_en or div_val while timer_en=1.
- wr_en = psel&penable&pwrite&pready, whether or not pslverr is raised.
  - addr and wdata are continuous passthroughs of paddr and pwdata.
  - The interrupt block decodes 0x14/0x18 itself.
- Counting:
  - Enabled when timer_en=1 and halted=0, where halted = halt_en & halt_req. halt_ack = halted.
  - div_en=0: cnt increments every enabled cycle.
  - div_en=1: an internal 8-bit div counter counts 0 .. (2^div_val - 1). cnt increments on the cycle the div counter equals its limit, and the div counter returns to 0.
  - The div counter freezes during halt.
  - cnt wraps from 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag.
  - The increment is a full 64-bit carry across TDR0 into TDR1 in the same cycle.
- timer_en written 1->0: cnt and div counter clear to 0 on the commit edge. A 0->1 write starts counting on the next cycle.
- Software write to TDR0 or TDR1 in the same cycle as an increment: the write wins for the written word, the other word keeps its pre-increment value, and the increment is lost.
- Simultaneous halt assert and TCR write: the TCR write commits normally.
- Reset mid-transfer: all registers go to reset values and pready/pslverr/prdata go to 0. The next transfer starts fresh.
- cnt/tcmp outputs are registered values with no additional latency.

Test Plan:
1. Reset -> TCR read returns 0x100, TCMP0/1 return 0xFFFF_FFFF, cnt=0. Every transfer shows pready low for 1 cycle, then high.
2. Write TCR=0x1 (div off), wait 10 cycles -> cnt advances by 1 per cycle. Write TCR=0x0 -> cnt=0 next cycle.
3. Write TCR=0x203 (div_val=2) -> cnt increments every 4 cycles. Writing TCR=0x303 while running -> pslverr=1 and TCR stays 0x203. Writing div_val=9 from stopped state -> pslverr=1.
4. Preload TDR0=0xFFFF_FFFF, TDR1=0xFFFF_FFFF, enable -> next cycle cnt=0. Preload TDR0=0xFFFF_FFFF, TDR1=0 -> cnt becomes 0x1_0000_0000.
5. Set THCSR.halt_en=1, assert halt_req for 5 cycles while running -> cnt frozen and THCSR reads 0x3. On release, counting resumes from the frozen value. With halt_en=0, halt_req has no effect.
6. Write TISR offset with pwdata=1 -> single-cycle wr_en pulse with addr=0x2000_0018 and wdata=1. A read of 0x14 returns tier_in, and pstrb=4'b0001 to TCMP0 changes only byte 0.
